// File: rtl/frame_ctrl_engine.sv
// frame_ctrl_engine
//   Tracks the lifecycle of one Ethernet frame at a time from accepted AXI-Stream beats.
//   Every accepted beat is tagged as header, payload or discard, and its index within the
//   frame is reported. One cycle after the tlast beat, a frame_end pulse carries the frame
//   length and the runt/oversize flags. These results hold until the next frame_end.
//
//   Optional build macro: FRAME_STATS_EN adds 32-bit saturating good/runt/oversize frame
//   counters with a synchronous clear. Without it, the stat outputs are tied to 0.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   beat_accept       tvalid && tready for the current beat
//   tlast, tkeep      end-of-frame marker and byte enables (tkeep counted on tlast only)
//   frame_start       current accepted beat opens a frame                    (combinational)
//   in_header         current accepted beat carries header bytes             (combinational)
//   in_payload        current accepted beat carries payload bytes            (combinational)
//   discard           current accepted beat belongs to an oversize frame     (combinational)
//   beat_idx          index of the current accepted beat within the frame    (combinational)
//   frame_end         one-cycle pulse after the tlast beat                   (registered)
//   frame_len         total frame bytes, valid with frame_end                (registered)
//   err_runt          frame shorter than MIN_FRAME_BYTES                     (registered)
//   err_oversize      frame longer than MAX_FRAME_BYTES                      (registered)
//   stat_clr          synchronous clear of the statistics counters
//   stat_good/stat_runt/stat_oversize  frame counters

module frame_ctrl_engine #(
    parameter int unsigned DATA_BYTES      = 8,
    parameter int unsigned HDR_BYTES       = 14,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned MAX_FRAME_BYTES = 1518,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_accept,
    input  logic                  tlast,
    input  logic [DATA_BYTES-1:0] tkeep,
    output logic                  frame_start,
    output logic                  in_header,
    output logic                  in_payload,
    output logic                  discard,
    output logic [CNT_W-1:0]      beat_idx,
    output logic                  frame_end,
    output logic [CNT_W-1:0]      frame_len,
    output logic                  err_runt,
    output logic                  err_oversize,
    input  logic                  stat_clr,
    output logic [31:0]           stat_good,
    output logic [31:0]           stat_runt,
    output logic [31:0]           stat_oversize
);

    localparam int unsigned HDR_BEATS = (HDR_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    // One spare bit so the running sum can detect counter overflow before saturating.
    localparam int unsigned SUM_W     = CNT_W + 1;
    // Wide enough for (beat_idx + 1) * DATA_BYTES with DATA_BYTES up to 64.
    localparam int unsigned IDX_W     = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StDiscard} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             ovf_q, ovf_d;
    logic             frame_end_q, frame_end_d;
    logic [CNT_W-1:0] frame_len_q, frame_len_d;
    logic             err_runt_q, err_runt_d;
    logic             err_oversize_q, err_oversize_d;

    logic             beat_vld;
    logic [SUM_W-1:0] keep_cnt;
    logic [SUM_W-1:0] beat_add;
    logic [SUM_W-1:0] sum_raw;
    logic [CNT_W-1:0] total;
    logic             over_now;
    logic             over_any;
    logic [IDX_W-1:0] beat_end_byte;

    // Reset also masks the combinational beat tags so every output reads 0 while in reset.
    assign beat_vld = beat_accept & rst_n;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            keep_cnt = keep_cnt + SUM_W'(tkeep[i]);
        end
    end

    always_comb begin
        beat_add      = tlast ? keep_cnt : SUM_W'(DATA_BYTES);
        sum_raw       = {1'b0, byte_cnt_q} + beat_add;
        total         = sum_raw[SUM_W-1] ? CNT_MAX : sum_raw[CNT_W-1:0];
        over_now      = sum_raw > SUM_W'(MAX_FRAME_BYTES);
        over_any      = ovf_q | over_now;
        beat_end_byte = (IDX_W'(beat_cnt_q) + IDX_W'(1)) * IDX_W'(DATA_BYTES);

        frame_start = beat_vld && (state_q == StIdle);
        beat_idx    = beat_vld ? beat_cnt_q : '0;
        discard     = beat_vld && ((state_q == StDiscard) || over_now);
        in_header   = beat_vld && !discard && (beat_cnt_q < CNT_W'(HDR_BEATS));
        in_payload  = beat_vld && !discard && (beat_end_byte > IDX_W'(HDR_BYTES));
    end

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        ovf_d          = ovf_q;
        frame_end_d    = 1'b0;
        frame_len_d    = frame_len_q;
        err_runt_d     = err_runt_q;
        err_oversize_d = err_oversize_q;

        if (beat_vld) begin
            if (tlast) begin
                state_d        = StIdle;
                beat_cnt_d     = '0;
                byte_cnt_d     = '0;
                ovf_d          = 1'b0;
                frame_end_d    = 1'b1;
                frame_len_d    = total;
                err_runt_d     = total < CNT_W'(MIN_FRAME_BYTES);
                err_oversize_d = over_any;
            end else begin
                beat_cnt_d = (beat_cnt_q == CNT_MAX) ? CNT_MAX : beat_cnt_q + CNT_W'(1);
                byte_cnt_d = total;
                ovf_d      = over_any;
                if (over_any) begin
                    state_d = StDiscard;
                end else begin
                    unique case (state_q)
                        StIdle:   state_d = (HDR_BEATS == 1) ? StPayload : StHeader;
                        StHeader: begin
                            if (beat_cnt_q == CNT_W'(HDR_BEATS - 1)) state_d = StPayload;
                        end
                        default:  state_d = state_q;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            beat_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            ovf_q          <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_len_q    <= '0;
            err_runt_q     <= 1'b0;
            err_oversize_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            ovf_q          <= ovf_d;
            frame_end_q    <= frame_end_d;
            frame_len_q    <= frame_len_d;
            err_runt_q     <= err_runt_d;
            err_oversize_q <= err_oversize_d;
        end
    end

    assign frame_end    = frame_end_q;
    assign frame_len    = frame_len_q;
    assign err_runt     = err_runt_q;
    assign err_oversize = err_oversize_q;

`ifdef FRAME_STATS_EN
    logic [31:0] stat_good_q, stat_good_d;
    logic [31:0] stat_runt_q, stat_runt_d;
    logic [31:0] stat_oversize_q, stat_oversize_d;

    // Counters update from the registered frame result, so they lag frame_end by one cycle.
    always_comb begin
        stat_good_d     = stat_good_q;
        stat_runt_d     = stat_runt_q;
        stat_oversize_d = stat_oversize_q;
        if (stat_clr) begin
            stat_good_d     = '0;
            stat_runt_d     = '0;
            stat_oversize_d = '0;
        end else if (frame_end_q) begin
            if (err_oversize_q) begin
                if (stat_oversize_q != '1) stat_oversize_d = stat_oversize_q + 32'd1;
            end else if (err_runt_q) begin
                if (stat_runt_q != '1) stat_runt_d = stat_runt_q + 32'd1;
            end else begin
                if (stat_good_q != '1) stat_good_d = stat_good_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_q     <= '0;
            stat_runt_q     <= '0;
            stat_oversize_q <= '0;
        end else begin
            stat_good_q     <= stat_good_d;
            stat_runt_q     <= stat_runt_d;
            stat_oversize_q <= stat_oversize_d;
        end
    end

    assign stat_good     = stat_good_q;
    assign stat_runt     = stat_runt_q;
    assign stat_oversize = stat_oversize_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_good       = '0;
    assign stat_runt       = '0;
    assign stat_oversize   = '0;
`endif

endmodule

// File: doc/frame_ctrl_engine.md
Name: frame_ctrl_engine

Overview:
Parametrised frame-lifecycle controller for the Ethernet frame parser. It tracks accepted AXI-Stream beats, computes the byte offset within the frame and tags every beat as header, payload or discard. At frame end it reports frame length plus runt and oversize errors. Its internal beat counter makes an external header_done unnecessary.

Parameters:
DATA_BYTES, 8, bytes per beat (power of 2, 1..64)
HDR_BYTES, 14, header length in bytes (>=1)
MIN_FRAME_BYTES, 60, frames shorter than this flag err_runt
MAX_FRAME_BYTES, 1518, frames longer than this flag err_oversize
CNT_W, 16, width of byte and beat counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
beat_accept  in  1  tvalid&&tready for the current beat
tlast  in  1  last beat of frame (qualified by beat_accept)
tkeep  in  DATA_BYTES  byte enables; counted on the tlast beat only
frame_start  out  1  current accepted beat is the first beat of a frame
in_header  out  1  current accepted beat carries header bytes
in_payload  out  1  current accepted beat carries payload bytes
discard  out  1  current accepted beat belongs to an oversize frame
beat_idx  out  CNT_W  index of the current beat within the frame
frame_end  out  1  registered pulse one cycle after the tlast beat
frame_len  out  CNT_W  total frame bytes, valid with frame_end
err_runt  out  1  valid with frame_end
err_oversize  out  1  valid with frame_end
stat_clr  in  1  synchronous clear of statistics counters
stat_good / stat_runt / stat_oversize  out  32 each  frame counters

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Reset forces state IDLE, counters 0 and all outputs 0.
- States: IDLE, HEADER, PAYLOAD, DISCARD. frame_end is a registered flag, not a state.
- HDR_BEATS = ceil(HDR_BYTES/DATA_BYTES).
- IDLE: an accepted beat gives frame_start=1 and beat_idx=0. With tlast, go to IDLE and finish the frame; else go to HEADER, or to PAYLOAD if HDR_BEATS==1.
- Outputs in_header, in_payload, frame_start, discard and beat_idx are combinational on the current accepted beat. All are 0 when beat_accept=0.
- in_header = (beat_idx < HDR_BEATS) && !discard.
- in_payload = ((beat_idx+1)*DATA_BYTES > HDR_BYTES) && !discard. On a straddling beat both are 1.
- HEADER goes to PAYLOAD on the accepted beat with beat_idx==HDR_BEATS-1.
- Byte accounting: non-last beats add DATA_BYTES; the tlast beat adds popcount(tkeep). tkeep is low-aligned and contiguous. tkeep=0 on the last beat adds 0.
- Oversize: on any accepted beat whose running total exceeds MAX_FRAME_BYTES:
  - that beat and all later beats of the frame get discard=1;
  - the state moves to DISCARD;
  - the sticky oversize flag is set.
- tlast in any state: on the next cycle, frame_end=1 for exactly one cycle and frame_len = final total. err_runt = total < MIN_FRAME_BYTES. err_oversize = sticky flag. A tlast inside the header counts as a runt. After tlast the state is IDLE.
- Back-to-back frames: a beat accepted in the cycle frame_end is high is a legal frame_start. frame_end and frame_start may be high together.
- Counter saturation: the byte counter saturates at 2^CNT_W-1 and beat_idx saturates likewise; the oversize flag is never lost.
- frame_len, err_runt and err_oversize hold their values until the next frame_end.
- Reset mid-frame discards the frame silently: no frame_end, no stats update.

Optional Feature:
FRAME_STATS_EN
- Defined: at each frame_end, exactly one of the three 32-bit saturating counters increments:
  - stat_oversize if err_oversize (takes priority);
  - else stat_runt if err_runt;
  - else stat_good.
  stat_clr zeroes all three and wins over a same-cycle increment.
- Undefined: the counters are absent, the stat outputs are tied to 0 and stat_clr is ignored.

Test Plan:
- All scenarios use DATA_BYTES=8, HDR=14, MIN=60, MAX=1518.
- 64-byte frame (8 beats, last tkeep=0xFF):
  - frame_start on beat0;
  - in_header on beats 0-1, in_payload on beats 1-7;
  - frame_end one cycle after beat7 with frame_len=64 and no errors.
- Single beat, tlast=1, tkeep=0x0F: frame_start=1 and in_header=1 that cycle; next cycle frame_end=1, frame_len=4, err_runt=1.
- 1600-byte frame (200 beats):
  - discard=0 through beat 188;
  - discard=1 from beat 189 (total 1520) through 199, with in_header/in_payload=0;
  - frame_end with frame_len=1600, err_oversize=1.
- Back-to-back, with beat_accept gaps inside a frame:
  - frame B starts the cycle after A's tlast; frame_end(A) and frame_start(B) are high together;
  - B's beat_idx restarts at 0;
  - idle gaps do not advance beat_idx.
- Reset asserted mid-payload: all outputs 0 immediately; no frame_end; the next accepted beat gives frame_start=1, beat_idx=0.
- FRAME_STATS_EN: 3 good, 1 runt and 1 oversize frame give counters 3/1/1. stat_clr asserted in the same cycle as a frame_end gives all counters 0.
